// File: rtl/r_control.sv
// Read-side pointer and flag controller of an asynchronous FIFO.
// Synchronises the write Gray pointer into rclk and derives registered empty/almost-empty/occupancy/underflow.
module r_control #(
    parameter int ADDSIZE  = 8,
    parameter int AE_LEVEL = 2
) (
    input  logic               rclk,
    input  logic               rrst_n,
    input  logic               rinc,
    input  logic [ADDSIZE:0]   wptr,
    output logic [ADDSIZE-1:0] raddr,
    output logic [ADDSIZE:0]   rptr,
    output logic               rempty,
    output logic               raempty,
    output logic [ADDSIZE:0]   rcount,
    output logic               runderflow
);

    localparam int               PW     = ADDSIZE + 1;
    localparam logic [ADDSIZE:0] AE_THR = PW'(AE_LEVEL);
    localparam logic [ADDSIZE:0] PZERO  = '0;

    function automatic logic [ADDSIZE:0] bin2gray(input logic [ADDSIZE:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [ADDSIZE:0] gray2bin(input logic [ADDSIZE:0] g);
        logic [ADDSIZE:0] b;
        b[ADDSIZE] = g[ADDSIZE];
        for (int i = ADDSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDSIZE:0] r_rbin;
    logic [ADDSIZE:0] r_rptr;
    logic [ADDSIZE:0] r_wptr_s1;
    logic [ADDSIZE:0] r_wptr_s2;
    logic             r_empty;
    logic             r_aempty;
    logic [ADDSIZE:0] r_count;
    logic             r_underflow;

    logic             w_rd_en;
    logic [ADDSIZE:0] w_rbin_next;
    logic [ADDSIZE:0] w_rgray_next;
    logic [ADDSIZE:0] w_wbin;
    logic [ADDSIZE:0] w_occ_next;

    // Next-state pointer and occupancy; all flags share one (wptr_s2, rbin_next) pair.
    always_comb begin
        w_rd_en      = rinc & ~r_empty;
        w_rbin_next  = r_rbin + {{ADDSIZE{1'b0}}, w_rd_en};
        w_rgray_next = bin2gray(w_rbin_next);
        w_wbin       = gray2bin(r_wptr_s2);
        w_occ_next   = w_wbin - w_rbin_next;
    end

    // Pointer, synchroniser and flag registers with synchronous active-low reset.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_rbin      <= PZERO;
            r_rptr      <= PZERO;
            r_wptr_s1   <= PZERO;
            r_wptr_s2   <= PZERO;
            r_empty     <= 1'b1;
            r_aempty    <= 1'b1;
            r_count     <= PZERO;
            r_underflow <= 1'b0;
        end else begin
            r_rbin      <= w_rbin_next;
            r_rptr      <= w_rgray_next;
            r_wptr_s1   <= wptr;
            r_wptr_s2   <= r_wptr_s1;
            r_empty     <= (w_rgray_next == r_wptr_s2);
            r_aempty    <= (w_occ_next <= AE_THR);
            r_count     <= w_occ_next;
            r_underflow <= r_underflow | (rinc & r_empty);
        end
    end

    assign raddr      = r_rbin[ADDSIZE-1:0];
    assign rptr       = r_rptr;
    assign rempty     = r_empty;
    assign raempty    = r_aempty;
    assign rcount     = r_count;
    assign runderflow = r_underflow;

endmodule

// File: tb/tb_r_control.sv
// Self-checking bench for r_control (ADDSIZE=3, AE_LEVEL=2): fixed vector table,
// hand sequences for reset/wrap, then random traffic against an occupancy-level model.
module tb_r_control;

    localparam int AS    = 3;
    localparam int AEL   = 2;
    localparam int DEPTH = 8;
    localparam int PMOD  = 16;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       rinc;
    logic [3:0] wptr;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [3:0] rcount;
    logic       runderflow;

    int tests = 0;
    int fails = 0;

    // Model: m_rd = entries consumed (mod 16); m_ws1/m_ws2 = write pointer as seen 1/2 edges ago.
    int m_rd, m_ws1, m_ws2, m_cnt, wbin;
    bit m_empty, m_ae, m_uf;

    r_control #(.ADDSIZE(AS), .AE_LEVEL(AEL)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .wptr(wptr),
        .raddr(raddr), .rptr(rptr), .rempty(rempty), .raempty(raempty),
        .rcount(rcount), .runderflow(runderflow)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic       rst_n;
        logic       rinc;
        logic [3:0] wptr;
        logic       e;
        logic       ae;
        logic [3:0] cnt;
        logic [2:0] addr;
        logic [3:0] ptr;
        logic       uf;
    } vec_t;

    vec_t vecs [16];

    function automatic int gray_of(input int v);
        return (v ^ (v >> 1)) & (PMOD - 1);
    endfunction

    function automatic int gray_decode(input int g);
        for (int v = 0; v < PMOD; v++) begin
            if (gray_of(v) == g) return v;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("raddr", int'(raddr), m_rd % DEPTH);
        chk("rptr", int'(rptr), gray_of(m_rd));
        chk("rcount", int'(rcount), m_cnt);
        chk("rempty", int'(rempty), int'(m_empty));
        chk("raempty", int'(raempty), int'(m_ae));
        chk("runderflow", int'(runderflow), int'(m_uf));
    endtask

    // Writer never exceeds DEPTH entries ahead of what has truly been consumed.
    task automatic drive_write(input bit want);
        if (want && (((wbin - m_rd + PMOD) % PMOD) < DEPTH)) wbin = (wbin + 1) % PMOD;
        wptr = 4'(gray_of(wbin));
    endtask

    task automatic step();
        bit acc;
        @(posedge rclk);
        if (!rrst_n) begin
            m_rd = 0; m_ws1 = 0; m_ws2 = 0; m_cnt = 0;
            m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
        end else begin
            acc     = rinc && !m_empty;
            m_uf    = m_uf || (rinc && m_empty);
            m_rd    = (m_rd + int'(acc)) % PMOD;
            m_cnt   = (gray_decode(m_ws2) - m_rd + PMOD) % PMOD;
            m_empty = (m_cnt == 0);
            m_ae    = (m_cnt <= AEL);
            m_ws2   = m_ws1;
            m_ws1   = int'(wptr);
        end
        #1;
        check_model();
    endtask

    initial begin
        bit         saw_wrap, saw_pwrap;
        logic [2:0] prev_addr;
        logic [3:0] prev_ptr;

        // rst rinc wptr   e  ae cnt addr ptr uf
        vecs[0]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 3'd0, 4'b0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 4'd0, 3'd0, 4'b0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 4'd0, 3'd0, 4'b0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 4'd1, 3'd0, 4'b0000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4'd7, 1'b0, 1'b1, 4'd1, 3'd0, 4'b0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'd7, 1'b0, 1'b1, 4'd1, 3'd0, 4'b0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 4'd5, 3'd0, 4'b0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 4'd4, 3'd1, 4'b0001, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 4'd3, 3'd2, 4'b0011, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 4'd7, 1'b0, 1'b1, 4'd2, 3'd3, 4'b0010, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 4'd7, 1'b0, 1'b1, 4'd1, 3'd4, 4'b0110, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 4'd0, 3'd5, 4'b0111, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 4'd0, 3'd5, 4'b0111, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 4'd0, 3'd5, 4'b0111, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 4'd0, 3'd5, 4'b0111, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 4'd7, 1'b1, 1'b1, 4'd0, 3'd5, 4'b0111, 1'b1};

        rrst_n = 1'b0; rinc = 1'b0; wptr = 4'd0; wbin = 0;
        m_rd = 0; m_ws1 = 0; m_ws2 = 0; m_cnt = 0;
        m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
        @(posedge rclk);
        #1;

        for (int i = 0; i < 16; i++) begin
            rrst_n = vecs[i].rst_n;
            rinc   = vecs[i].rinc;
            wptr   = vecs[i].wptr;
            step();
            chk($sformatf("vec%0d_rempty", i), int'(rempty), int'(vecs[i].e));
            chk($sformatf("vec%0d_raempty", i), int'(raempty), int'(vecs[i].ae));
            chk($sformatf("vec%0d_rcount", i), int'(rcount), int'(vecs[i].cnt));
            chk($sformatf("vec%0d_raddr", i), int'(raddr), int'(vecs[i].addr));
            chk($sformatf("vec%0d_rptr", i), int'(rptr), int'(vecs[i].ptr));
            chk($sformatf("vec%0d_runderflow", i), int'(runderflow), int'(vecs[i].uf));
        end
        wbin = 5;

        // Fill to four entries, then reset mid-stream with the write side reset alongside.
        rinc = 1'b0;
        for (int i = 0; i < 4; i++) begin drive_write(1'b1); step(); end
        for (int i = 0; i < 3; i++) begin drive_write(1'b0); step(); end
        chk("mid_rcount", int'(rcount), 4);
        rrst_n = 1'b0; wbin = 0; wptr = 4'd0;
        step();
        chk("rst_raddr", int'(raddr), 0);
        chk("rst_rptr", int'(rptr), 0);
        chk("rst_rcount", int'(rcount), 0);
        chk("rst_rempty", int'(rempty), 1);
        chk("rst_raempty", int'(raempty), 1);
        chk("rst_runderflow", int'(runderflow), 0);
        rrst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin drive_write(1'b1); step(); end
        chk("resume_raddr", int'(raddr), 0);

        // Continuous read and write through both address and pointer wrap.
        saw_wrap = 1'b0; saw_pwrap = 1'b0;
        rinc = 1'b1;
        for (int i = 0; i < 60; i++) begin
            prev_addr = raddr;
            prev_ptr  = rptr;
            drive_write(1'b1);
            step();
            if (prev_addr == 3'd7 && raddr == 3'd0) saw_wrap = 1'b1;
            if (prev_ptr == 4'b1000 && rptr == 4'b0000) saw_pwrap = 1'b1;
        end
        chk("raddr_wrap_seen", int'(saw_wrap), 1);
        chk("rptr_wrap_seen", int'(saw_pwrap), 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rinc = ($urandom_range(0, 3) != 0);
            drive_write(bit'($urandom_range(0, 1)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
